// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array front end.
// Sizes derive from a per-instance ARRAY_SIZE via the helper functions; the localparams describe the default N=3 build.
package systolic_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} feeder_state_t;

   function automatic int row_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_ARRAY_SIZE = 3;
   localparam int FEED_CYCLES    = 2 * DEF_ARRAY_SIZE;
   localparam int ROW_W          = row_w(DEF_ARRAY_SIZE);

endpackage

// File: rtl/matrix_row_buffer.sv
// N x N operand store: one full-row write port, ARRAY_SIZE independent (row, col) element read ports.
module matrix_row_buffer
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_SIZE = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [row_w(ARRAY_SIZE)-1:0]     wr_row,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wr_data,
   input  logic [row_w(ARRAY_SIZE)-1:0]     rd_row  [0:ARRAY_SIZE-1],
   input  logic [row_w(ARRAY_SIZE)-1:0]     rd_col  [0:ARRAY_SIZE-1],
   output logic [DATA_WIDTH-1:0]            rd_data [0:ARRAY_SIZE-1]
);

   logic [DATA_WIDTH-1:0] mem [0:ARRAY_SIZE-1][0:ARRAY_SIZE-1];

   // Row write; out-of-range row indices are dropped rather than aliased.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < ARRAY_SIZE; r++) begin
            for (int c = 0; c < ARRAY_SIZE; c++) begin
               mem[r][c] <= '0;
            end
         end
      end else if (wr_en && (int'(wr_row) < ARRAY_SIZE)) begin
         for (int c = 0; c < ARRAY_SIZE; c++) begin
            mem[wr_row][c] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      for (int p = 0; p < ARRAY_SIZE; p++) begin
         rd_data[p] = '0;
         if ((int'(rd_row[p]) < ARRAY_SIZE) && (int'(rd_col[p]) < ARRAY_SIZE)) begin
            rd_data[p] = mem[rd_row[p]][rd_col[p]];
         end else begin
            rd_data[p] = '0;
         end
      end
   end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers A and B, then clears the array and feeds A rows / B columns on a diagonal skew.
// Waits for computation_done (or a drain timeout) and reports completion to the controller.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ARRAY_SIZE    = 3,
   parameter int DRAIN_TIMEOUT = 4 * ARRAY_SIZE
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load_valid,
   output logic                             load_ready,
   input  logic                             load_sel,
   input  logic [row_w(ARRAY_SIZE)-1:0]     load_row,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] load_data,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic                             error,
   output logic                             arr_rst_n,
   output logic                             arr_enable,
   output logic [DATA_WIDTH-1:0]            arr_a [0:ARRAY_SIZE-1],
   output logic [DATA_WIDTH-1:0]            arr_b [0:ARRAY_SIZE-1],
   input  logic                             arr_done
);

   localparam int RW       = row_w(ARRAY_SIZE);
   localparam int FEED_LEN = 2 * ARRAY_SIZE;
   localparam int KW       = $clog2(FEED_LEN + 1);
   localparam int TW       = $clog2(DRAIN_TIMEOUT + 1);

   feeder_state_t         state;
   logic [KW-1:0]         k;
   logic [KW-1:0]         nxt_k;
   logic [TW-1:0]         timer;
   logic                  flag;
   logic                  wr_a;
   logic                  wr_b;
   logic                  lane_ok [0:ARRAY_SIZE-1];
   logic [RW-1:0]         a_row   [0:ARRAY_SIZE-1];
   logic [RW-1:0]         a_col   [0:ARRAY_SIZE-1];
   logic [RW-1:0]         b_row   [0:ARRAY_SIZE-1];
   logic [RW-1:0]         b_col   [0:ARRAY_SIZE-1];
   logic [DATA_WIDTH-1:0] a_rd    [0:ARRAY_SIZE-1];
   logic [DATA_WIDTH-1:0] b_rd    [0:ARRAY_SIZE-1];

   assign load_ready = (state == IDLE);
   assign busy       = (state != IDLE);
   assign wr_a       = load_valid && load_ready && !load_sel;
   assign wr_b       = load_valid && load_ready &&  load_sel;

   matrix_row_buffer #(.DATA_WIDTH(DATA_WIDTH), .ARRAY_SIZE(ARRAY_SIZE)) u_buf_a (
      .clk(clk), .rst(rst), .wr_en(wr_a), .wr_row(load_row), .wr_data(load_data),
      .rd_row(a_row), .rd_col(a_col), .rd_data(a_rd)
   );

   matrix_row_buffer #(.DATA_WIDTH(DATA_WIDTH), .ARRAY_SIZE(ARRAY_SIZE)) u_buf_b (
      .clk(clk), .rst(rst), .wr_en(wr_b), .wr_row(load_row), .wr_data(load_data),
      .rd_row(b_row), .rd_col(b_col), .rd_data(b_rd)
   );

   // Skew addressing for the feed step about to be registered: lane p sees diagonal index nxt_k - p.
   always_comb begin
      nxt_k = (state == FEED) ? (k + {{(KW-1){1'b0}}, 1'b1}) : '0;
      for (int p = 0; p < ARRAY_SIZE; p++) begin
         a_row[p]   = RW'(p);
         b_col[p]   = RW'(p);
         a_col[p]   = '0;
         b_row[p]   = '0;
         lane_ok[p] = 1'b0;
         if ((nxt_k >= KW'(p)) && ((nxt_k - KW'(p)) < KW'(ARRAY_SIZE))) begin
            a_col[p]   = RW'(nxt_k - KW'(p));
            b_row[p]   = RW'(nxt_k - KW'(p));
            lane_ok[p] = 1'b1;
         end else begin
            lane_ok[p] = 1'b0;
         end
      end
   end

   // Job sequencer; every array-facing output is registered for the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         timer      <= '0;
         flag       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         arr_rst_n  <= 1'b0;
         arr_enable <= 1'b0;
         for (int p = 0; p < ARRAY_SIZE; p++) begin
            arr_a[p] <= '0;
            arr_b[p] <= '0;
         end
      end else begin
         done       <= 1'b0;
         arr_rst_n  <= 1'b1;
         arr_enable <= 1'b0;
         for (int p = 0; p < ARRAY_SIZE; p++) begin
            arr_a[p] <= '0;
            arr_b[p] <= '0;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= CLEAR;
                  arr_rst_n <= 1'b0;
                  flag      <= 1'b0;
               end
            end
            CLEAR: begin
               state      <= FEED;
               k          <= '0;
               arr_enable <= 1'b1;
               for (int p = 0; p < ARRAY_SIZE; p++) begin
                  arr_a[p] <= lane_ok[p] ? a_rd[p] : '0;
                  arr_b[p] <= lane_ok[p] ? b_rd[p] : '0;
               end
            end
            FEED: begin
               arr_enable <= 1'b1;
               if (arr_done) begin
                  flag <= 1'b1;
               end
               if (k == KW'(FEED_LEN - 1)) begin
                  if (flag || arr_done) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     error      <= 1'b0;
                     arr_enable <= 1'b0;
                  end else begin
                     state <= DRAIN;
                     timer <= '0;
                  end
               end else begin
                  k <= nxt_k;
                  for (int p = 0; p < ARRAY_SIZE; p++) begin
                     arr_a[p] <= lane_ok[p] ? a_rd[p] : '0;
                     arr_b[p] <= lane_ok[p] ? b_rd[p] : '0;
                  end
               end
            end
            DRAIN: begin
               arr_enable <= 1'b1;
               if (arr_done) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  error      <= 1'b0;
                  arr_enable <= 1'b0;
               end else if (timer == TW'(DRAIN_TIMEOUT - 1)) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  error      <= 1'b1;
                  arr_enable <= 1'b0;
               end else begin
                  timer <= timer + {{(TW-1){1'b0}}, 1'b1};
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed and randomized bench for systolic_skew_feeder against a matrix-level reference model.
module tb_systolic_skew_feeder;

   localparam int N  = 3;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_valid;
   logic          load_ready;
   logic          load_sel;
   logic [1:0]    load_row;
   logic [N*DW-1:0] load_data;
   logic          start;
   logic          busy;
   logic          done;
   logic          error;
   logic          arr_rst_n;
   logic          arr_enable;
   logic [DW-1:0] arr_a [0:N-1];
   logic [DW-1:0] arr_b [0:N-1];
   logic          arr_done;

   int total = 0;
   int bad   = 0;
   int ma [N][N];
   int mb [N][N];

   systolic_skew_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(N), .DRAIN_TIMEOUT(4*N)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_sel(load_sel), .load_row(load_row), .load_data(load_data),
      .start(start), .busy(busy), .done(done), .error(error),
      .arr_rst_n(arr_rst_n), .arr_enable(arr_enable),
      .arr_a(arr_a), .arr_b(arr_b), .arr_done(arr_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ea(input int i, input int k);
      return (k >= i && k - i < N) ? ma[i][k-i] : 0;
   endfunction

   function automatic int eb(input int j, input int k);
      return (k >= j && k - j < N) ? mb[k-j][j] : 0;
   endfunction

   task automatic model_write(input bit sel, input int row, input logic [N*DW-1:0] data);
      if (row < N) begin
         for (int c = 0; c < N; c++) begin
            if (sel) mb[row][c] = int'(data[c*DW +: DW]);
            else     ma[row][c] = int'(data[c*DW +: DW]);
         end
      end
   endtask

   task automatic do_load(input bit sel, input int row, input logic [N*DW-1:0] data);
      load_valid = 1'b1;
      load_sel   = sel;
      load_row   = 2'(row);
      load_data  = data;
      @(posedge clk); #1;
      load_valid = 1'b0;
      model_write(sel, row, data);
   endtask

   // kd: FEED step at which arr_done pulses (-1 none); dd: DRAIN cycle with arr_done (0 none)
   task automatic run_job(input int kd, input int dd, input bit poke);
      int  drains;
      bit  seen;
      int  exp_drains;
      bit  exp_err;
      exp_drains = (kd >= 0) ? 0 : ((dd > 0) ? dd : 4*N);
      exp_err    = (kd < 0) && (dd == 0);
      start = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      load_valid = 1'b0;
      @(negedge clk);
      chk("clear_rst_n", arr_rst_n, 0);
      chk("clear_enable", arr_enable, 0);
      chk("clear_busy", busy, 1);
      chk("clear_a0", arr_a[0], 0);
      for (int k = 0; k < 2*N; k++) begin
         @(posedge clk); #1;
         arr_done   = (k == kd);
         load_valid = 1'b0;
         start      = 1'b0;
         if (poke && k == 1) begin
            load_valid = 1'b1;
            load_sel   = 1'b0;
            load_row   = 2'd0;
            load_data  = 24'h090909;
            start      = 1'b1;
         end
         @(negedge clk);
         chk("feed_enable", arr_enable, 1);
         chk("feed_rst_n", arr_rst_n, 1);
         chk("feed_ready", load_ready, 0);
         for (int i = 0; i < N; i++) begin
            chk($sformatf("feed_a k=%0d i=%0d", k, i), arr_a[i], ea(i, k));
            chk($sformatf("feed_b k=%0d j=%0d", k, i), arr_b[i], eb(i, k));
         end
      end
      drains = 0;
      seen   = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(posedge clk); #1;
         load_valid = 1'b0;
         start      = 1'b0;
         arr_done   = (dd != 0) && (drains + 1 == dd) && (kd < 0);
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
         end else begin
            drains++;
            chk("drain_enable", arr_enable, 1);
            chk("drain_a0", arr_a[0], 0);
            chk("drain_busy", busy, 1);
         end
      end
      arr_done = 1'b0;
      chk("done_seen", seen, 1);
      chk("drain_cycles", drains, exp_drains);
      chk("done_error", error, exp_err);
      chk("done_enable", arr_enable, 0);
      chk("done_busy", busy, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_ready", load_ready, 1);
      chk("error_hold", error, exp_err);
   endtask

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_sel   = 1'b0;
      load_row   = 2'd0;
      load_data  = '0;
      start      = 1'b0;
      arr_done   = 1'b0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 0;
            mb[r][c] = 0;
         end
      end

      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_arr_rst_n", arr_rst_n, 0);
      chk("rst_enable", arr_enable, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_busy", busy, 0);
      chk("rst_a1", arr_a[1], 0);
      chk("rst_b2", arr_b[2], 0);
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_rst_n", arr_rst_n, 1);
      chk("post_rst_ready", load_ready, 1);

      // skew order with A = 1..9, B = identity
      do_load(1'b0, 0, {8'd3, 8'd2, 8'd1});
      do_load(1'b0, 1, {8'd6, 8'd5, 8'd4});
      do_load(1'b0, 2, {8'd9, 8'd8, 8'd7});
      do_load(1'b1, 0, 24'h000001);
      do_load(1'b1, 1, 24'h000100);
      do_load(1'b1, 2, 24'h010000);
      run_job(-1, 3, 1'b0);

      run_job(-1, 0, 1'b0);
      run_job(-1, 12, 1'b0);
      run_job(5, 0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < 5; w++) begin
            do_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 24'($urandom));
         end
         if (r < 2) run_job(int'($urandom_range(0, 5)), 0, 1'b0);
         else       run_job(-1, int'($urandom_range(1, 12)), 1'b0);
      end

      // busy protection, then an identical rerun
      run_job(-1, 2, 1'b1);
      run_job(-1, 2, 1'b0);

      // load and start in the same cycle
      load_valid = 1'b1;
      load_sel   = 1'b0;
      load_row   = 2'd0;
      load_data  = 24'h090909;
      model_write(1'b0, 0, 24'h090909);
      run_job(-1, 1, 1'b0);

      // reset during FEED step k=2
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_rst_n", arr_rst_n, 0);
      chk("midrst_enable", arr_enable, 0);
      chk("midrst_done", done, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_a0", arr_a[0], 0);
      chk("midrst_b0", arr_b[0], 0);
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            ma[r][c] = 0;
            mb[r][c] = 0;
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_after_done", done, 0);
      chk("midrst_after_rst_n", arr_rst_n, 1);
      run_job(-1, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
